// File: rtl/timer_ctrl.sv
// Prescaled seconds timer with alarm, auto-reload and a small register file.
// A 32-bit prescale counter produces one tick per PRESCALE+1 clocks while
// running; each tick advances the seconds counter and may raise the alarm.
module timer_ctrl #(
  parameter logic [31:0] DEFAULT_PRESCALE = 32'd79999999,
  parameter int          CNT_W            = 16
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             cfg_we,
  input  logic [1:0]       cfg_addr,
  input  logic [31:0]      cfg_wdata,
  output logic [31:0]      cfg_rdata,
  input  logic             cmd_start,
  input  logic             cmd_stop,
  input  logic             cmd_clear,
  output logic             tick_o,
  output logic [CNT_W-1:0] seconds_o,
  output logic [1:0]       state_o,
  output logic             irq_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_ALARM = 2'd3
  } state_t;

  localparam logic [1:0] ADDR_PRESCALE = 2'd0;
  localparam logic [1:0] ADDR_ALARM    = 2'd1;
  localparam logic [1:0] ADDR_CTRL     = 2'd2;
  localparam logic [1:0] ADDR_STATUS   = 2'd3;

  state_t             state_reg;
  logic [31:0]        prescale_reg;
  logic [CNT_W-1:0]   alarm_reg;
  logic               alarm_en_reg;
  logic               auto_reload_reg;
  logic [31:0]        count_reg;
  logic [CNT_W-1:0]   seconds_reg;
  logic               tick_reg;
  logic               irq_reg;

  logic [CNT_W-1:0]   seconds_inc;
  logic               period_done;
  logic               alarm_hit;
  logic               status_clr;

  // Seconds+1 is compared against ALARM in CNT_W bits, so it wraps like the counter.
  assign seconds_inc = seconds_reg + {{(CNT_W-1){1'b0}}, 1'b1};
  assign period_done = (count_reg >= prescale_reg);
  assign alarm_hit   = alarm_en_reg && (seconds_inc == alarm_reg);
  assign status_clr  = cfg_we && (cfg_addr == ADDR_STATUS) && cfg_wdata[0];

  // Configuration registers; new values are seen by the datapath one cycle later.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      prescale_reg    <= DEFAULT_PRESCALE;
      alarm_reg       <= '0;
      alarm_en_reg    <= 1'b0;
      auto_reload_reg <= 1'b0;
    end else if (cfg_we) begin
      case (cfg_addr)
        ADDR_PRESCALE: prescale_reg <= cfg_wdata;
        ADDR_ALARM:    alarm_reg    <= cfg_wdata[CNT_W-1:0];
        ADDR_CTRL: begin
          alarm_en_reg    <= cfg_wdata[0];
          auto_reload_reg <= cfg_wdata[1];
        end
        default: ;
      endcase
    end
  end

  // Run-control FSM with prescale counter, seconds counter, tick pulse and sticky irq.
  // The irq clear is written before any set so a same-cycle alarm wins.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_reg   <= ST_IDLE;
      count_reg   <= '0;
      seconds_reg <= '0;
      tick_reg    <= 1'b0;
      irq_reg     <= 1'b0;
    end else begin
      tick_reg <= 1'b0;
      if (status_clr) begin
        irq_reg <= 1'b0;
      end
      if (cmd_clear) begin
        state_reg   <= ST_IDLE;
        count_reg   <= '0;
        seconds_reg <= '0;
        irq_reg     <= 1'b0;
      end else begin
        case (state_reg)
          ST_IDLE, ST_PAUSE: begin
            // A concurrent stop outranks start, and stop is a no-op here.
            if (!cmd_stop && cmd_start) begin
              state_reg <= ST_RUN;
            end
          end
          ST_RUN: begin
            if (cmd_stop) begin
              state_reg <= ST_PAUSE;
            end else if (period_done) begin
              count_reg <= '0;
              tick_reg  <= 1'b1;
              if (alarm_hit) begin
                irq_reg <= 1'b1;
                if (auto_reload_reg) begin
                  seconds_reg <= '0;
                end else begin
                  seconds_reg <= alarm_reg;
                  state_reg   <= ST_ALARM;
                end
              end else begin
                seconds_reg <= seconds_inc;
              end
            end else begin
              count_reg <= count_reg + 32'd1;
            end
          end
          default: ; // ST_ALARM holds everything until a clear
        endcase
      end
    end
  end

  // Combinational register read-back.
  always_comb begin
    cfg_rdata = '0;
    case (cfg_addr)
      ADDR_PRESCALE: cfg_rdata = prescale_reg;
      ADDR_ALARM:    cfg_rdata[CNT_W-1:0] = alarm_reg;
      ADDR_CTRL:     cfg_rdata[1:0] = {auto_reload_reg, alarm_en_reg};
      default: begin
        cfg_rdata[CNT_W-1:0]   = seconds_reg;
        cfg_rdata[CNT_W +: 2]  = state_reg;
        cfg_rdata[CNT_W + 2]   = irq_reg;
      end
    endcase
  end

  assign tick_o    = tick_reg;
  assign seconds_o = seconds_reg;
  assign state_o   = state_reg;
  assign irq_o     = irq_reg;

endmodule

// File: tb/tb_timer_ctrl.sv
// Testbench for timer_ctrl: directed scenarios plus randomized traffic
// compared against a rule-level reference model kept in the bench.
module tb_timer_ctrl;

  localparam int          CNT_W = 16;
  localparam int          SMOD  = 1 << CNT_W;
  localparam logic [31:0] DEF_PRE = 32'd79999999;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_addr = 2'd0;
  logic [31:0] cfg_wdata = 32'd0;
  logic [31:0] cfg_rdata;
  logic        cmd_start = 1'b0;
  logic        cmd_stop = 1'b0;
  logic        cmd_clear = 1'b0;
  logic        tick_o;
  logic [CNT_W-1:0] seconds_o;
  logic [1:0]  state_o;
  logic        irq_o;

  int pass_cnt = 0;
  int total_cnt = 0;

  timer_ctrl #(.DEFAULT_PRESCALE(DEF_PRE), .CNT_W(CNT_W)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .cfg_we   (cfg_we),
    .cfg_addr (cfg_addr),
    .cfg_wdata(cfg_wdata),
    .cfg_rdata(cfg_rdata),
    .cmd_start(cmd_start),
    .cmd_stop (cmd_stop),
    .cmd_clear(cmd_clear),
    .tick_o   (tick_o),
    .seconds_o(seconds_o),
    .state_o  (state_o),
    .irq_o    (irq_o)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // States: 0 idle, 1 run, 2 pause, 3 alarm.
  int          m_state;
  int          m_sec;
  logic [31:0] m_cnt;
  logic [31:0] m_pre;
  int          m_alarm;
  logic        m_en, m_ar, m_tick, m_irq;

  always @(posedge clk) begin
    if (rst) begin
      m_state = 0; m_sec = 0; m_cnt = 0; m_tick = 0; m_irq = 0;
      m_pre = DEF_PRE; m_alarm = 0; m_en = 0; m_ar = 0;
    end else begin
      m_tick = 0;
      if (cfg_we && cfg_addr == 2'd3 && cfg_wdata[0]) m_irq = 0;
      if (cmd_clear) begin
        m_state = 0; m_sec = 0; m_cnt = 0; m_irq = 0;
      end else if (cmd_stop) begin
        if (m_state == 1) m_state = 2;
      end else if (cmd_start && (m_state == 0 || m_state == 2)) begin
        m_state = 1;
      end else if (m_state == 1) begin
        if (m_cnt >= m_pre) begin
          m_cnt = 0;
          m_tick = 1;
          if (m_en && ((m_sec + 1) % SMOD) == m_alarm) begin
            m_irq = 1;
            if (m_ar) m_sec = 0;
            else begin m_sec = m_alarm; m_state = 3; end
          end else begin
            m_sec = (m_sec + 1) % SMOD;
          end
        end else begin
          m_cnt = m_cnt + 1;
        end
      end
      if (cfg_we) begin
        case (cfg_addr)
          2'd0: m_pre = cfg_wdata;
          2'd1: m_alarm = int'(cfg_wdata[CNT_W-1:0]);
          2'd2: begin m_en = cfg_wdata[0]; m_ar = cfg_wdata[1]; end
          default: ;
        endcase
      end
    end
  end

  function automatic logic [31:0] model_rdata(input logic [1:0] a);
    case (a)
      2'd0: return m_pre;
      2'd1: return 32'(m_alarm);
      2'd2: return {30'd0, m_ar, m_en};
      default: return (32'(m_irq) << 18) | (32'(m_state) << 16) | 32'(m_sec);
    endcase
  endfunction

  // ---------------- stimulus helpers (no checking) ----------------
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    @(negedge clk);
    cfg_we = 1'b0; cfg_wdata = 32'd0;
  endtask

  task automatic pulse_start();
    cmd_start = 1'b1; @(negedge clk); cmd_start = 1'b0;
  endtask

  task automatic pulse_stop();
    cmd_stop = 1'b1; @(negedge clk); cmd_stop = 1'b0;
  endtask

  task automatic pulse_clear();
    cmd_clear = 1'b1; @(negedge clk); cmd_clear = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [31:0] exp_rd [3];
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    total_cnt++;
    if ({tick_o, irq_o, state_o, seconds_o} !== 20'd0) $display("FAIL reset_outputs got=%h exp=0", {tick_o, irq_o, state_o, seconds_o});
    else pass_cnt++;
    exp_rd[0] = DEF_PRE; exp_rd[1] = 32'd0; exp_rd[2] = 32'd0;
    for (int a = 0; a < 3; a++) begin
      cfg_addr = 2'(a); #1;
      total_cnt++;
      if (cfg_rdata !== exp_rd[a]) $display("FAIL reset_reg%0d got=%h exp=%h", a, cfg_rdata, exp_rd[a]);
      else pass_cnt++;
    end
    $display("test_reset done");
  endtask

  task automatic test_periodic();
    wr(2'd0, 32'd3);
    pulse_start();
    total_cnt++;
    if (state_o !== 2'd1) $display("FAIL periodic_state got=%0d exp=1", state_o);
    else pass_cnt++;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      total_cnt++;
      if (tick_o !== (c % 4 == 0) || seconds_o !== 16'(c / 4))
        $display("FAIL periodic_c%0d got tick=%0d sec=%0d exp tick=%0d sec=%0d", c, tick_o, seconds_o, (c % 4 == 0), c / 4);
      else pass_cnt++;
    end
    pulse_clear();
    $display("test_periodic done");
  endtask

  task automatic test_alarm_stop();
    wr(2'd1, 32'd5);
    wr(2'd2, 32'd1);
    pulse_start();
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 16) begin
        total_cnt++;
        if (seconds_o !== 16'd4 || state_o !== 2'd1 || irq_o !== 1'b0)
          $display("FAIL alarm_pre got sec=%0d st=%0d irq=%0d exp sec=4 st=1 irq=0", seconds_o, state_o, irq_o);
        else pass_cnt++;
      end
    end
    total_cnt++;
    if (seconds_o !== 16'd5 || state_o !== 2'd3 || irq_o !== 1'b1 || tick_o !== 1'b1)
      $display("FAIL alarm_hit got sec=%0d st=%0d irq=%0d tick=%0d exp sec=5 st=3 irq=1 tick=1", seconds_o, state_o, irq_o, tick_o);
    else pass_cnt++;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      total_cnt++;
      if (tick_o !== 1'b0 || seconds_o !== 16'd5 || state_o !== 2'd3)
        $display("FAIL alarm_hold got tick=%0d sec=%0d st=%0d exp tick=0 sec=5 st=3", tick_o, seconds_o, state_o);
      else pass_cnt++;
    end
    pulse_clear();
    total_cnt++;
    if (state_o !== 2'd0 || seconds_o !== 16'd0 || irq_o !== 1'b0)
      $display("FAIL alarm_clear got st=%0d sec=%0d irq=%0d exp 0 0 0", state_o, seconds_o, irq_o);
    else pass_cnt++;
    $display("test_alarm_stop done");
  endtask

  task automatic test_auto_reload();
    int exp_sec [4] = '{1, 0, 1, 0};
    int exp_irq [4] = '{0, 1, 1, 1};
    wr(2'd2, 32'd3);
    wr(2'd1, 32'd2);
    wr(2'd0, 32'd0);
    pulse_start();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      total_cnt++;
      if (seconds_o !== 16'(exp_sec[c]) || irq_o !== 1'(exp_irq[c]) || state_o !== 2'd1)
        $display("FAIL reload_c%0d got sec=%0d irq=%0d st=%0d exp sec=%0d irq=%0d st=1", c, seconds_o, irq_o, state_o, exp_sec[c], exp_irq[c]);
      else pass_cnt++;
    end
    wr(2'd3, 32'd1);
    total_cnt++;
    if (irq_o !== 1'b0 || seconds_o !== 16'd1) $display("FAIL status_clear got irq=%0d sec=%0d exp irq=0 sec=1", irq_o, seconds_o);
    else pass_cnt++;
    wr(2'd3, 32'd1);
    total_cnt++;
    if (irq_o !== 1'b1 || seconds_o !== 16'd0) $display("FAIL set_beats_clear got irq=%0d sec=%0d exp irq=1 sec=0", irq_o, seconds_o);
    else pass_cnt++;
    wr(2'd3, 32'hFFFF_FFFE);
    total_cnt++;
    if (irq_o !== 1'b1) $display("FAIL status_upper_ignored got irq=%0d exp=1", irq_o);
    else pass_cnt++;
    pulse_clear();
    $display("test_auto_reload done");
  endtask

  task automatic test_pause_resume();
    wr(2'd2, 32'd0);
    wr(2'd0, 32'd9);
    pulse_start();
    repeat (2) @(negedge clk);
    pulse_stop();
    total_cnt++;
    if (state_o !== 2'd2) $display("FAIL pause_state got=%0d exp=2", state_o);
    else pass_cnt++;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      total_cnt++;
      if (tick_o !== 1'b0 || state_o !== 2'd2) $display("FAIL pause_hold got tick=%0d st=%0d exp tick=0 st=2", tick_o, state_o);
      else pass_cnt++;
    end
    pulse_start();
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      total_cnt++;
      if (tick_o !== (i == 8) || state_o !== 2'd1)
        $display("FAIL resume_i%0d got tick=%0d st=%0d exp tick=%0d st=1", i, tick_o, state_o, (i == 8));
      else pass_cnt++;
    end
    total_cnt++;
    if (seconds_o !== 16'd1) $display("FAIL resume_sec got=%0d exp=1", seconds_o);
    else pass_cnt++;
    cmd_stop = 1'b1; cmd_start = 1'b1;
    @(negedge clk);
    cmd_stop = 1'b0; cmd_start = 1'b0;
    total_cnt++;
    if (state_o !== 2'd2) $display("FAIL stop_start_prio got=%0d exp=2", state_o);
    else pass_cnt++;
    pulse_clear();
    $display("test_pause_resume done");
  endtask

  task automatic test_prescale_write();
    wr(2'd0, 32'd9);
    pulse_start();
    repeat (5) @(negedge clk);
    wr(2'd0, 32'd2);
    total_cnt++;
    if (tick_o !== 1'b0) $display("FAIL pre_write_edge got tick=%0d exp=0", tick_o);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (tick_o !== 1'b1 || seconds_o !== 16'd1) $display("FAIL pre_write_tick got tick=%0d sec=%0d exp tick=1 sec=1", tick_o, seconds_o);
    else pass_cnt++;
    pulse_clear();
    wr(2'd0, 32'd3);
    pulse_start();
    repeat (3) @(negedge clk);
    pulse_clear();
    total_cnt++;
    if (tick_o !== 1'b0 || seconds_o !== 16'd0 || state_o !== 2'd0)
      $display("FAIL clear_vs_tick got tick=%0d sec=%0d st=%0d exp 0 0 0", tick_o, seconds_o, state_o);
    else pass_cnt++;
    $display("test_prescale_write done");
  endtask

  task automatic test_wrap();
    wr(2'd2, 32'd0);
    wr(2'd0, 32'd0);
    pulse_start();
    repeat (65535) @(negedge clk);
    total_cnt++;
    if (seconds_o !== 16'hFFFF) $display("FAIL wrap_top got=%h exp=ffff", seconds_o);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (seconds_o !== 16'd0 || irq_o !== 1'b0 || tick_o !== 1'b1 || state_o !== 2'd1)
      $display("FAIL wrap_zero got sec=%0d irq=%0d tick=%0d st=%0d exp sec=0 irq=0 tick=1 st=1", seconds_o, irq_o, tick_o, state_o);
    else pass_cnt++;
    pulse_clear();
    $display("test_wrap done");
  endtask

  task automatic test_reset_mid_run();
    wr(2'd0, 32'd99);
    pulse_start();
    repeat (150) @(negedge clk);
    rst = 1'b1; cmd_start = 1'b1;
    @(negedge clk);
    rst = 1'b0; cmd_start = 1'b0;
    total_cnt++;
    if ({tick_o, irq_o, state_o, seconds_o} !== 20'd0) $display("FAIL midrun_reset got=%h exp=0", {tick_o, irq_o, state_o, seconds_o});
    else pass_cnt++;
    cfg_addr = 2'd0; #1;
    total_cnt++;
    if (cfg_rdata !== DEF_PRE) $display("FAIL midrun_prescale got=%0d exp=%0d", cfg_rdata, DEF_PRE);
    else pass_cnt++;
    repeat (5) @(negedge clk);
    total_cnt++;
    if (state_o !== 2'd0 || seconds_o !== 16'd0) $display("FAIL midrun_idle got st=%0d sec=%0d exp 0 0", state_o, seconds_o);
    else pass_cnt++;
    $display("test_reset_mid_run done");
  endtask

  task automatic test_random();
    logic [19:0] got, exp;
    logic [31:0] exp_rd;
    int errs = 0;
    for (int n = 0; n < 3000; n++) begin
      got = {tick_o, irq_o, state_o, seconds_o};
      exp = {m_tick, m_irq, 2'(m_state), 16'(m_sec)};
      total_cnt++;
      if (got !== exp) begin
        errs++;
        $display("FAIL random_out n=%0d got=%h exp=%h", n, got, exp);
      end else pass_cnt++;
      rst       = ($urandom_range(0, 299) == 0);
      cmd_clear = ($urandom_range(0, 39) == 0);
      cmd_stop  = ($urandom_range(0, 14) == 0);
      cmd_start = ($urandom_range(0, 5) == 0);
      cfg_we    = ($urandom_range(0, 9) == 0);
      cfg_addr  = 2'($urandom_range(0, 3));
      case (cfg_addr)
        2'd0: cfg_wdata = $urandom_range(0, 6);
        2'd1: cfg_wdata = {$urandom, 3'($urandom_range(0, 7))} ;
        2'd2: cfg_wdata = $urandom;
        default: cfg_wdata = $urandom;
      endcase
      if (cfg_addr == 2'd1) cfg_wdata = ($urandom & 32'hFFFF_0000) | 32'($urandom_range(0, 7));
      #1;
      exp_rd = model_rdata(cfg_addr);
      total_cnt++;
      if (cfg_rdata !== exp_rd) begin
        errs++;
        $display("FAIL random_rd n=%0d addr=%0d got=%h exp=%h", n, cfg_addr, cfg_rdata, exp_rd);
      end else pass_cnt++;
      @(negedge clk);
    end
    rst = 1'b0; cmd_clear = 1'b0; cmd_stop = 1'b0; cmd_start = 1'b0; cfg_we = 1'b0;
    $display("test_random done errors=%0d", errs);
  endtask

  initial begin
    test_reset();
    test_periodic();
    test_alarm_stop();
    test_auto_reload();
    test_pause_resume();
    test_prescale_write();
    test_wrap();
    test_reset_mid_run();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/timer_ctrl.md
TIMER_CTRL -- requirements
Module: timer_ctrl

Interface
REQ-001 Parameter DEFAULT_PRESCALE, default 79999999, reset value of PRESCALE (one tick per 80,000,000 clocks).
REQ-002 Parameter CNT_W, default 16, width of the seconds counter and ALARM.
REQ-003 wb_clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 wb_rst_i  input  1  synchronous, active-high reset.
REQ-005 cfg_we  input  1  register write strobe; a write completes in the same cycle.
REQ-006 cfg_addr  input  2  register select: 0 PRESCALE, 1 ALARM, 2 CTRL, 3 STATUS.
REQ-007 cfg_wdata  input  32  write data.
REQ-008 cfg_rdata  output  32  combinational read of the register at cfg_addr.
REQ-009 cmd_start  input  1  run request, level-sampled each cycle.
REQ-010 cmd_stop  input  1  pause request, level-sampled each cycle.
REQ-011 cmd_clear  input  1  clear request, level-sampled each cycle.
REQ-012 tick_o  output  1  one-cycle pulse per elapsed prescale period.
REQ-013 seconds_o  output  CNT_W  elapsed-tick count.
REQ-014 state_o  output  2  FSM state: 0 IDLE, 1 RUN, 2 PAUSE, 3 ALARM.
REQ-015 irq_o  output  1  sticky alarm interrupt.

Function
REQ-016 Registers and fields:
- PRESCALE[31:0]: read/write.
- ALARM[CNT_W-1:0]: read/write; upper read bits are 0.
- CTRL: bit0 alarm_en, bit1 auto_reload; other bits read 0.
- STATUS: read {irq_o, state_o, seconds_o} packed LSB-first; writing 1 to bit0 clears irq_o.
REQ-017 Command priority is cmd_clear > cmd_stop > cmd_start; only the highest-priority asserted command acts in a cycle.
REQ-018 cmd_clear, in any state: next state IDLE; seconds_o, the prescale counter and irq_o go to 0.
REQ-019 cmd_start takes IDLE->RUN and PAUSE->RUN; it is ignored in RUN and ALARM.
REQ-020 cmd_stop takes RUN->PAUSE with the prescale counter held; it is ignored in other states.
REQ-021 Prescale counter behaviour:
- Counts only in RUN.
- When the counter is >= PRESCALE, it loads 0, and on the same edge tick_o=1 and seconds_o increments; otherwise the counter increments and tick_o=0.
- The tick period is therefore PRESCALE+1 clocks; PRESCALE=0 ticks every clock.
REQ-022 seconds_o wraps from 2^CNT_W-1 to 0 without an alarm unless the alarm condition (REQ-023) holds.
REQ-023 Alarm condition: a tick occurs with alarm_en=1 and seconds_o+1 == ALARM.
- If auto_reload=1: seconds_o loads 0, the state stays RUN and irq_o sets.
- If auto_reload=0: seconds_o loads ALARM, the state becomes ALARM, the prescale counter clears and irq_o sets.
REQ-024 In ALARM, seconds_o and the counter hold; only cmd_clear exits.
REQ-025 A PRESCALE write during RUN takes effect on the next cycle's compare; if the counter already exceeds the new value, a tick fires on that next edge.
REQ-026 If an irq set and a STATUS bit0 clear write occur in the same cycle, the set wins.
REQ-027 Writes to ALARM and CTRL take effect on the next cycle.
REQ-028 Writes to STATUS bits other than bit0 are ignored.
REQ-029 A cmd_clear in the same cycle as a tick suppresses the tick: tick_o=0 and seconds_o=0 on the next edge.

Reset
REQ-030 While wb_rst_i=1 at a clock edge, all of the following hold on the next cycle, and commands and writes are ignored:
- state IDLE;
- seconds_o=0, tick_o=0, irq_o=0;
- prescale counter 0;
- PRESCALE=DEFAULT_PRESCALE, ALARM=0, CTRL=0.
REQ-031 Reset asserted mid-RUN discards the partial prescale count; after release the block stays in IDLE until cmd_start.

Verification
REQ-032 Write PRESCALE=3, pulse cmd_start -> tick_o every 4 clocks, seconds_o 1,2,3...; state_o=1.
REQ-033 PRESCALE=3, ALARM=5, CTRL=1, start -> on the 5th tick seconds_o=5, state_o=3, irq_o=1; later ticks do not occur; cmd_clear -> state_o=0, seconds_o=0, irq_o=0.
REQ-034 CTRL=3, ALARM=2, PRESCALE=0 -> seconds_o sequence 1,0,1,0 with irq_o set after the second tick and held; write STATUS=1 -> irq_o=0.
REQ-035 Run, assert cmd_stop after 2 counter cycles with PRESCALE=9, hold 20 clocks, then cmd_start -> the next tick occurs 8 clocks after restart; a simultaneous stop+start pauses.
REQ-036 PRESCALE=0, preload to 0xFFFF ticks with alarm_en=0 -> seconds_o wraps to 0 with irq_o=0.
REQ-037 Assert wb_rst_i mid-RUN with PRESCALE=99 -> all outputs 0, PRESCALE reads 79999999 after release.
